program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/loader_pkg.sv | 19 +
 rtl/sat_counter.sv | 28 ++
 rtl/program_loader.sv | 146 ++++++++++++++
 tb/tb_program_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

  localparam int unsigned WORD_W             = 32;
  localparam int unsigned DEFAULT_IMEM_DEPTH = 256;
  localparam int unsigned DEFAULT_ADDR_W     = 8;

  // An all-zero word ends the program image.
  localparam logic [WORD_W-1:0] TERMINATOR = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_FLUSH,
    ST_RUN,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset (async, active-low) ; enable : count this cycle
//   clear : reload INIT (wins over enable) ; count : current value
module sat_counter #(
  parameter int unsigned       WIDTH = 32,
  parameter logic [WIDTH-1:0]  INIT  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  // Counter register; holds at all-ones once reached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= INIT;
    end else if (clear) begin
      count <= INIT;
    end else if (enable && (count != MAX_VAL)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a program into instruction memory, holds the CPU in reset while
// loading, then releases it and counts run cycles until end_program.
//   clk, reset (async, active-low)
//   in_valid/in_data/in_ready : program word stream (0 = terminator)
//   imem_we/imem_addr/imem_wdata : instruction-memory write port
//   cpu_reset : active-high CPU hold ; end_program : CPU completion
//   load_done, run_done, overflow_err : status ; cycle_count : run cycles
// CYCLE_COUNT_INIT sets the counter's reset/clear value (0 in normal use).
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH       = DEFAULT_IMEM_DEPTH,
  parameter int unsigned ADDR_W           = DEFAULT_ADDR_W,
  parameter logic [31:0] CYCLE_COUNT_INIT = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  input  logic              end_program,
  output logic              load_done,
  output logic              run_done,
  output logic              overflow_err,
  output logic [31:0]       cycle_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

  loader_state_e     state_q;
  loader_state_e     state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic              hs_c;
  logic              ready_d;
  logic              cpu_reset_d;
  logic              load_done_d;
  logic              run_done_d;
  logic              overflow_d;
  logic              cnt_en_c;
  logic              cnt_clr_c;

  assign hs_c = in_valid & in_ready;

  // State and status registers; status is decoded from the next state so
  // every output changes on the same edge as the state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_LOAD;
      in_ready     <= 1'b0;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      run_done     <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready     <= ready_d;
      cpu_reset    <= cpu_reset_d;
      load_done    <= load_done_d;
      run_done     <= run_done_d;
      overflow_err <= overflow_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: begin
        if (hs_c) begin
          if (in_data == TERMINATOR) begin
            state_d = ST_FLUSH;
          end else if (ptr_q == LAST_ADDR) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      ST_RUN: begin
        if (end_program) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Output decode of the next state.
  always_comb begin
    ready_d     = 1'b0;
    cpu_reset_d = 1'b1;
    load_done_d = 1'b0;
    run_done_d  = 1'b0;
    overflow_d  = 1'b0;
    case (state_d)
      ST_LOAD:  ready_d = 1'b1;
      ST_RUN: begin
        cpu_reset_d = 1'b0;
        load_done_d = 1'b1;
      end
      ST_DONE: begin
        cpu_reset_d = 1'b0;
        load_done_d = 1'b1;
        run_done_d  = 1'b1;
      end
      ST_ERROR: overflow_d = 1'b1;
      default: ;
    endcase
  end

  // Write port: one-cycle registered copy of each accepted word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= hs_c;
      if (hs_c) begin
        imem_addr  <= ptr_q;
        imem_wdata <= in_data;
        ptr_q      <= ptr_q + ADDR_W'(1);
      end
    end
  end

  // The cycle of end_program is not counted; LOAD re-arms the counter.
  assign cnt_en_c  = (state_q == ST_RUN) & ~end_program;
  assign cnt_clr_c = (state_q == ST_LOAD);

  sat_counter #(
    .WIDTH (32),
    .INIT  (CYCLE_COUNT_INIT)
  ) u_cycle_counter (
    .clk    (clk),
    .reset  (reset),
    .enable (cnt_en_c),
    .clear  (cnt_clr_c),
    .count  (cycle_count)
  );

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: scoreboarded write port, randomized load gaps
// and run lengths, overflow and saturation on a small second instance.
module tb_program_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: default geometry.
  logic        a_rst = 1'b1;
  logic        a_valid = 1'b0;
  logic [31:0] a_data = 32'h0;
  logic        a_ready, a_we, a_cpu_rst, a_ld, a_rd, a_ovf;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata, a_cnt;
  logic        a_end = 1'b0;

  // Instance B: 4-word memory, counter preset near saturation.
  logic        b_rst = 1'b1;
  logic        b_valid = 1'b0;
  logic [31:0] b_data = 32'h0;
  logic        b_ready, b_we, b_cpu_rst, b_ld, b_rd, b_ovf;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata, b_cnt;
  logic        b_end = 1'b0;

  program_loader dut_a (
    .clk(clk), .reset(a_rst), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_ready), .imem_we(a_we), .imem_addr(a_addr),
    .imem_wdata(a_wdata), .cpu_reset(a_cpu_rst), .end_program(a_end),
    .load_done(a_ld), .run_done(a_rd), .overflow_err(a_ovf),
    .cycle_count(a_cnt)
  );

  program_loader #(
    .IMEM_DEPTH(4), .ADDR_W(2), .CYCLE_COUNT_INIT(32'hFFFF_FFFE)
  ) dut_b (
    .clk(clk), .reset(b_rst), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready), .imem_we(b_we), .imem_addr(b_addr),
    .imem_wdata(b_wdata), .cpu_reset(b_cpu_rst), .end_program(b_end),
    .load_done(b_ld), .run_done(b_rd), .overflow_err(b_ovf),
    .cycle_count(b_cnt)
  );

  // Reference model: expected memory writes in acceptance order.
  wr_t qa[$];
  wr_t qb[$];
  int  a_ptr = 0;
  int  b_ptr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (a_we === 1'b1) begin
      chk("a_write_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_wr_addr", 32'(a_addr), e.addr);
        chk("a_wr_data", a_wdata, e.data);
      end
    end
    if (b_we === 1'b1) begin
      chk("b_write_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_wr_addr", 32'(b_addr), e.addr);
        chk("b_wr_data", b_wdata, e.data);
      end
    end
  end

  // Offer one word to A after 'gap' idle cycles; end_program toggles randomly.
  task automatic send_a(input logic [31:0] w, input int gap);
    bit hs = 1'b0;
    repeat (gap) begin
      a_valid = 1'b0;
      a_end   = 1'($urandom);
      @(posedge clk); #1;
    end
    a_valid = 1'b1;
    a_data  = w;
    for (int i = 0; i < 50 && !hs; i++) begin
      a_end = 1'($urandom);
      @(negedge clk);
      hs = a_ready;
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    a_data  = $urandom;
    chk("a_handshake", 32'(hs), 32'd1);
    if (hs) begin
      qa.push_back('{32'(a_ptr), w});
      a_ptr++;
    end
  endtask

  task automatic send_b(input logic [31:0] w);
    bit hs = 1'b0;
    b_valid = 1'b1;
    b_data  = w;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      hs = b_ready;
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    chk("b_handshake", 32'(hs), 32'd1);
    if (hs) begin
      qb.push_back('{32'(b_ptr), w});
      b_ptr++;
    end
  endtask

  task automatic reset_a();
    a_rst   = 1'b0;
    a_valid = 1'b0;
    a_end   = 1'b0;
    qa.delete();
    a_ptr = 0;
    @(negedge clk);
    a_rst = 1'b1;
    chk("a_ready_before_first_edge", 32'(a_ready), 32'd0);
    @(posedge clk); #1;
    chk("a_ready_after_reset", 32'(a_ready), 32'd1);
  endtask

  task automatic reset_b();
    b_rst   = 1'b0;
    b_valid = 1'b0;
    b_end   = 1'b0;
    qb.delete();
    b_ptr = 0;
    @(negedge clk);
    b_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Called just after the terminator handshake; runs n counted cycles.
  task automatic run_a(input int n);
    a_end = 1'b1;
    chk("a_flush_cpu_reset", 32'(a_cpu_rst), 32'd1);
    chk("a_flush_ready", 32'(a_ready), 32'd0);
    chk("a_flush_load_done", 32'(a_ld), 32'd0);
    @(posedge clk); #1;
    a_end = 1'b0;
    chk("a_run_cpu_reset", 32'(a_cpu_rst), 32'd0);
    chk("a_run_load_done", 32'(a_ld), 32'd1);
    chk("a_run_count_start", a_cnt, 32'd0);
    chk("a_image_drained", 32'(qa.size()), 32'd0);
    repeat (n) begin @(posedge clk); #1; end
    chk("a_count_before_end", a_cnt, 32'(n));
    a_end = 1'b1;
    @(posedge clk); #1;
    a_end = 1'b0;
    chk("a_run_done", 32'(a_rd), 32'd1);
    chk("a_count_at_end", a_cnt, 32'(n));
    repeat (4) begin
      a_end = 1'($urandom);
      @(posedge clk); #1;
    end
    chk("a_count_frozen", a_cnt, 32'(n));
    chk("a_done_terminal", 32'(a_rd), 32'd1);
    chk("a_done_cpu_reset", 32'(a_cpu_rst), 32'd0);
    chk("a_no_overflow", 32'(a_ovf), 32'd0);
  endtask

  logic [31:0] prog[6] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193,
                           32'h0040_0213, 32'h0050_0293, 32'h0000_0000};

  initial begin
    int len;
    #2;
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_we", 32'(a_we), 32'd0);
    chk("rst_cpu_reset", 32'(a_cpu_rst), 32'd1);
    chk("rst_flags", {29'd0, a_ld, a_rd, a_ovf}, 32'd0);
    chk("rst_count", a_cnt, 32'd0);

    // Back-to-back program; end_program on the 8th RUN cycle.
    reset_a();
    foreach (prog[i]) send_a(prog[i], 0);
    run_a(7);

    // Same program with valid low every other cycle.
    reset_a();
    foreach (prog[i]) send_a(prog[i], 1);
    run_a($urandom_range(1, 30));

    // Reset right after the third word: write in flight is cancelled.
    reset_a();
    for (int i = 0; i < 3; i++) send_a(prog[i], 0);
    a_rst = 1'b0;
    #1;
    chk("midrst_we", 32'(a_we), 32'd0);
    chk("midrst_addr", 32'(a_addr), 32'd0);
    chk("midrst_wdata", a_wdata, 32'd0);
    chk("midrst_ready", 32'(a_ready), 32'd0);
    chk("midrst_cpu_reset", 32'(a_cpu_rst), 32'd1);
    chk("midrst_flags", {29'd0, a_ld, a_rd, a_ovf}, 32'd0);
    chk("midrst_count", a_cnt, 32'd0);
    reset_a();
    len = $urandom_range(3, 20);
    for (int i = 0; i < len; i++) send_a($urandom | 32'h1, $urandom_range(0, 3));
    send_a(32'h0, $urandom_range(0, 3));
    run_a($urandom_range(1, 40));

    // Overflow: four non-zero words into a 4-word memory.
    reset_b();
    for (int i = 0; i < 4; i++) send_b($urandom | 32'h1);
    chk("b_ovf_flag", 32'(b_ovf), 32'd1);
    chk("b_ovf_cpu_reset", 32'(b_cpu_rst), 32'd1);
    chk("b_ovf_ready", 32'(b_ready), 32'd0);
    chk("b_ovf_load_done", 32'(b_ld), 32'd0);
    b_valid = 1'b1;
    b_data  = 32'hDEAD_BEEF;
    b_end   = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    b_valid = 1'b0;
    b_end   = 1'b0;
    chk("b_ovf_terminal", 32'(b_ovf), 32'd1);
    chk("b_ovf_ready_held", 32'(b_ready), 32'd0);
    chk("b_no_extra_write", 32'(qb.size()), 32'd0);

    // Terminator in the last slot loads normally; counter saturates.
    reset_b();
    for (int i = 0; i < 3; i++) send_b($urandom | 32'h1);
    send_b(32'h0);
    chk("b_last_term_no_ovf", 32'(b_ovf), 32'd0);
    @(posedge clk); #1;
    chk("b_run_load_done", 32'(b_ld), 32'd1);
    chk("b_run_count_start", b_cnt, 32'hFFFF_FFFE);
    repeat (5) begin @(posedge clk); #1; end
    chk("b_count_saturated", b_cnt, 32'hFFFF_FFFF);
    b_end = 1'b1;
    @(posedge clk); #1;
    b_end = 1'b0;
    chk("b_run_done", 32'(b_rd), 32'd1);
    chk("b_count_final", b_cnt, 32'hFFFF_FFFF);

    @(posedge clk); #1;
    chk("a_queue_empty", 32'(qa.size()), 32'd0);
    chk("b_queue_empty", 32'(qb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
